// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// RAM handshake state, arbiter FSM state and grant side encodings.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 32;
  localparam int unsigned DATA_W_DEFAULT  = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hBAD1_BAD1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Datapath request/response and single-port RAM signals seen by the arbiter.
// slave = arbiter view, master = datapath + RAM view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);

  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              ihit;
  logic [DATA_W-1:0] imemload;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              bus_err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramstate,
    output ihit, imemload, dhit, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramstate,
    input  ihit, imemload, dhit, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

endinterface

// File: rtl/mem_arbiter_timeout_counter.sv
// Saturating wait-cycle counter; expired_c flags the LIMIT-th enabled cycle.
module mem_arbiter_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(LIMIT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // True during the cycle whose increment would bring the count to LIMIT.
  assign expired_c = enable && (count >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto a single-port variable-latency RAM.
// Data has priority; last_grant alternates grants under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned       TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_WORD_DEFAULT)
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  arb_state_t state;
  grant_t     last_grant;

  logic              d_req_c;
  logic              grant_d_c;
  logic              grant_i_c;
  logic              wait_c;
  logic              access_c;
  logic              fail_c;
  logic              end_c;
  logic              expired_c;
  logic [ADDR_W-1:0] grant_addr_c;
  logic [DATA_W-1:0] resp_c;

  // Data wins unless fetch is also pending and data had the previous grant.
  assign d_req_c      = bus.dmemREN | bus.dmemWEN;
  assign grant_d_c    = (state == IDLE) && d_req_c &&
                        (!bus.imemREN || (last_grant == INSTR));
  assign grant_i_c    = (state == IDLE) && !grant_d_c && bus.imemREN;
  assign grant_addr_c = grant_d_c ? bus.dmemaddr : bus.imemaddr;

  assign wait_c   = (state == I_WAIT) || (state == D_WAIT);
  assign access_c = (bus.ramstate == ACCESS);
  assign fail_c   = (bus.ramstate == ERROR) || expired_c;
  assign end_c    = wait_c && (access_c || fail_c);
  assign resp_c   = access_c ? bus.ramload : ERR_WORD;

  mem_arbiter_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (CLK),
    .rst_n     (nRST),
    .clear     (grant_d_c || grant_i_c),
    .enable    (wait_c),
    .expired_c (expired_c)
  );

  // Arbiter FSM with registered RAM strobes and completion pulses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      last_grant   <= INSTR;
      bus.ihit     <= 1'b0;
      bus.dhit     <= 1'b0;
      bus.imemload <= '0;
      bus.dmemload <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
      bus.bus_err  <= 1'b0;
    end else begin
      bus.ihit <= 1'b0;
      bus.dhit <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d_c || grant_i_c) begin
            bus.ramaddr <= grant_addr_c;
          end
          if (grant_d_c) begin
            state        <= D_WAIT;
            last_grant   <= DATA;
            bus.ramstore <= bus.dmemstore;
            // A simultaneous load+store request is executed as a store.
            bus.ramWEN   <= bus.dmemWEN;
            bus.ramREN   <= bus.dmemREN && !bus.dmemWEN;
            if (bus.dmemREN && bus.dmemWEN) begin
              bus.bus_err <= 1'b1;
            end
          end else if (grant_i_c) begin
            state      <= I_WAIT;
            last_grant <= INSTR;
            bus.ramREN <= 1'b1;
            bus.ramWEN <= 1'b0;
          end
        end
        I_WAIT, D_WAIT: begin
          if (end_c) begin
            state      <= DONE;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            if (!access_c) begin
              bus.bus_err <= 1'b1;
            end
            // Hit is dropped if the requester has withdrawn by completion.
            if (state == I_WAIT) begin
              bus.imemload <= resp_c;
              bus.ihit     <= bus.imemREN;
            end else begin
              bus.dmemload <= resp_c;
              bus.dhit     <= d_req_c;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the datapath request unit.
- Consumes its imemREN / dmemREN / dmemWEN request levels, plus the fetch address, data address and store data from the datapath.
- Serialises them onto the single-ported, variable-latency RAM and returns one-cycle ihit / dhit completion pulses with read data.
- Data requests have priority, with a fairness rule so fetch is never starved. A timeout and a RAM error path guarantee every accepted request completes.

Parameters:
- ADDR_W, 32, address width (word address in bits [ADDR_W-1:2]).
- DATA_W, 32, data word width.
- TIMEOUT, 15, maximum RAM wait cycles before forced error completion; must be ≥1.
- ERR_WORD, 32'hBAD1BAD1, read data returned on an error completion.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- nRST  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- imemREN  in  1  instruction fetch request level.
- imemaddr  in  ADDR_W  fetch address.
- dmemREN  in  1  data load request level.
- dmemWEN  in  1  data store request level.
- dmemaddr  in  ADDR_W  data address.
- dmemstore  in  DATA_W  store data.
- ihit  out  1  one-cycle fetch completion.
- imemload  out  DATA_W  fetch data; valid while ihit=1.
- dhit  out  1  one-cycle load/store completion.
- dmemload  out  DATA_W  load data; valid while dhit=1 for a load.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- bus_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values:
  - All outputs 0: ihit, dhit, ramREN, ramWEN, bus_err, and all data/address outputs.
  - state=IDLE, last_grant=INSTR, wait counter 0.
- States: IDLE, I_WAIT, D_WAIT, DONE.
- Grant in IDLE (evaluated each cycle):
  - If a data request is pending (dmemREN|dmemWEN) and either imemREN=0 or last_grant=INSTR, grant data → D_WAIT.
  - Otherwise, if imemREN is pending, grant instruction → I_WAIT.
  - Otherwise stay in IDLE.
  - On grant: latch address, op, and store data into registers; update last_grant.
  - Consequence: when both requests are continuously pending, grants strictly alternate.
- dmemREN and dmemWEN both high at grant: treat as a store; set bus_err.
- I_WAIT / D_WAIT:
  - Drive ramaddr and ramstore from latches; ramREN=1 (or ramWEN=1 for a store); wait counter increments each cycle.
  - ramstate=ACCESS: capture ramload into the response register → DONE.
  - ramstate=ERROR, or counter reaches TIMEOUT: response register = ERR_WORD, set bus_err → DONE.
  - FREE / BUSY: keep waiting.
- DONE (exactly one cycle):
  - ramREN=ramWEN=0.
  - Pulse ihit or dhit for the granted side, with imemload or dmemload = response register.
  - Go to IDLE.
- Latency: minimum 3 cycles from request to hit (grant, one RAM ACCESS cycle, DONE). A new grant may occur in the cycle after DONE.
- Request withdrawn mid-transaction (granted side's REN/WEN low in DONE):
  - The RAM access still completes.
  - The hit pulse is suppressed.
  - No other state change.
- Never more than one of ihit / dhit high in any cycle; ramREN and ramWEN are never both high.
- Wait counter: width $clog2(TIMEOUT+1), cleared on every grant, saturates.
- Asynchronous reset mid-transaction: immediate return to the reset values; the in-flight RAM access is abandoned.

Decomposition:
- cpu_types_pkg:
  - ramstate_t, if not already present.
  - arb_state_t {IDLE, I_WAIT, D_WAIT, DONE}.
  - grant_t {INSTR, DATA}.
  - ERR_WORD default constant.
- One sub-module is natural: arb_timeout_counter (clear, enable, saturate, expired flag).

Test Plan:
- Fetch only: imemREN=1, addr 0x0000_0040, ramstate=ACCESS on the 2nd wait cycle with ramload 0x2401_0005 → ihit pulses once with imemload=0x2401_0005; ramREN high exactly 2 cycles.
- Contention: imemREN=1 and dmemREN=1 held, ramstate=ACCESS every cycle → grants alternate D, I, D, I; ihit and dhit are never simultaneous.
- Store: dmemWEN=1, addr 0x0000_3000, dmemstore 0xDEAD_BEEF → ramWEN=1 with ramaddr=0x3000 and ramstore=0xDEADBEEF; dhit pulses once; ramREN stays 0.
- Timeout: ramstate held BUSY, TIMEOUT=15 → dhit after the 15th wait cycle with dmemload=0xBAD1BAD1; bus_err=1 and stays 1.
- Withdrawal and reset:
  - dmemREN dropped during D_WAIT → no dhit; next fetch is served normally.
  - nRST pulsed low during I_WAIT → ramREN=0 immediately; state=IDLE.
